// File: rtl/banyan_seq_pkg.sv
// Shared definitions for the banyan capture sequencer.
//   seq_state_t : sequencer state encoding
//   MASK_W      : banyan channel mask width
//   FILL_BLANK  : FILL cycles during which the full flag is ignored, because
//                 the memory reset issued by the trigger clears full a little later
package banyan_seq_pkg;

   localparam int MASK_W     = 8;
   localparam int FILL_BLANK = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SETTLE  = 3'd2,
      TRIG    = 3'd3,
      FILL    = 3'd4,
      READOUT = 3'd5
   } seq_state_t;

endpackage

// File: rtl/banyan_mask_table.sv
// Mask table: 2**SAW entries of MASK_W bits, one per capture step.
// Cleared by reset, written synchronously, read combinationally.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   we/waddr/wdata : host write port
//   raddr/rdata  : combinational read port
module banyan_mask_table
   import banyan_seq_pkg::*;
#(
   parameter int SAW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [SAW-1:0]    waddr,
   input  logic [MASK_W-1:0] wdata,
   input  logic [SAW-1:0]    raddr,
   output logic [MASK_W-1:0] rdata
);

   localparam int DEPTH = 2**SAW;

   logic [MASK_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/banyan_capture_sequencer.sv
// Banyan capture sequencer: steps through a host-loaded list of banyan masks,
// applying each mask, waiting a settle time, firing one capture trigger,
// waiting for the capture memory to fill, then handing the buffer to the
// reader via readout_req/readout_ack.
//
// Optional feature macro: BANYAN_SEQ_LOOP_EN adds input loop_en; when high,
// the last step's ack restarts the list at step 0 instead of finishing.
//
// Ports:
//   clk, rst_n            : capture clock, async active-low reset
//   start, abort          : single-cycle control pulses
//   mask_we/waddr/wdata   : mask-table write port
//   n_steps               : steps per sequence (saturates at 2**SAW)
//   settle_cycles         : settle delay after a mask change
//   timeout_cycles        : fill timeout, 0 disables
//   full, readout_ack     : capture memory full flag, reader ack
//   banyan_mask, capture_trig, readout_req : drives to memory / reader
//   busy, done, timeout_err, step_idx      : status
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | drive mask of current step
// SETTLE  | settle countdown after the mask change
// TRIG    | one-cycle capture trigger
// FILL    | wait for full (blanked first cycles), optional timeout
// READOUT | readout_req high until ack
module banyan_capture_sequencer
   import banyan_seq_pkg::*;
#(
   parameter int SAW = 2,
   parameter int TW  = 20,
   parameter int SW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mask_we,
   input  logic [SAW-1:0]    mask_waddr,
   input  logic [MASK_W-1:0] mask_wdata,
   input  logic [SAW:0]      n_steps,
   input  logic [SW-1:0]     settle_cycles,
   input  logic [TW-1:0]     timeout_cycles,
   input  logic              full,
   input  logic              readout_ack,
`ifdef BANYAN_SEQ_LOOP_EN
   input  logic              loop_en,
`endif
   output logic [MASK_W-1:0] banyan_mask,
   output logic              capture_trig,
   output logic              readout_req,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [SAW-1:0]    step_idx
);

   localparam logic [SAW:0] DEPTH   = (SAW+1)'(2**SAW);
   localparam logic [SAW:0] ONE     = (SAW+1)'(1);
   localparam logic [1:0]   BLANK_N = 2'(FILL_BLANK);

   seq_state_t        state;
   logic [SW-1:0]     settle_cnt;
   logic [TW-1:0]     fill_cnt;
   logic              to_en;
   logic [1:0]        blank_cnt;
   logic [MASK_W-1:0] table_mask;
   logic [SAW:0]      eff_steps;
   logic              last_step;
   logic              loop_active;

   banyan_mask_table #(.SAW(SAW)) u_mask_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mask_we),
      .waddr (mask_waddr),
      .wdata (mask_wdata),
      .raddr (step_idx),
      .rdata (table_mask)
   );

`ifdef BANYAN_SEQ_LOOP_EN
   assign loop_active = loop_en;
`else
   assign loop_active = 1'b0;
`endif

   assign eff_steps = (n_steps > DEPTH) ? DEPTH : n_steps;
   assign last_step = ({1'b0, step_idx} == (eff_steps - ONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         fill_cnt     <= '0;
         to_en        <= 1'b0;
         blank_cnt    <= '0;
         banyan_mask  <= '0;
         capture_trig <= 1'b0;
         readout_req  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_err  <= 1'b0;
         step_idx     <= '0;
      end else begin
         capture_trig <= 1'b0;
         done         <= 1'b0;
         if (abort) begin
            state       <= IDLE;
            readout_req <= 1'b0;
            banyan_mask <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && (n_steps != '0)) begin
                     state       <= LOAD;
                     step_idx    <= '0;
                     timeout_err <= 1'b0;
                     busy        <= 1'b1;
                  end
               end
               LOAD: begin
                  banyan_mask <= table_mask;
                  settle_cnt  <= settle_cycles;
                  state       <= SETTLE;
               end
               SETTLE: begin
                  if (settle_cnt == '0) begin
                     state        <= TRIG;
                     capture_trig <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               TRIG: begin
                  fill_cnt  <= timeout_cycles;
                  to_en     <= (timeout_cycles != '0);
                  blank_cnt <= BLANK_N;
                  state     <= FILL;
               end
               FILL: begin
                  if (blank_cnt != '0) begin
                     blank_cnt <= blank_cnt - 1'b1;
                  end
                  // A full seen in the same cycle as expiry still wins.
                  if ((blank_cnt == '0) && full) begin
                     state       <= READOUT;
                     readout_req <= 1'b1;
                  end else if (to_en && (fill_cnt == '0)) begin
                     timeout_err <= 1'b1;
                     banyan_mask <= '0;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end else if (to_en) begin
                     fill_cnt <= fill_cnt - 1'b1;
                  end
               end
               READOUT: begin
                  if (readout_ack) begin
                     readout_req <= 1'b0;
                     if (!last_step) begin
                        step_idx <= step_idx + 1'b1;
                        state    <= LOAD;
                     end else if (loop_active) begin
                        step_idx <= '0;
                        state    <= LOAD;
                     end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_banyan_capture_sequencer.sv
module tb_banyan_capture_sequencer;

   localparam int SAW = 2;
   localparam int TW  = 20;
   localparam int SW  = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start, abort, mask_we;
   logic [SAW-1:0] mask_waddr;
   logic [7:0]     mask_wdata;
   logic [SAW:0]   n_steps;
   logic [SW-1:0]  settle_cycles;
   logic [TW-1:0]  timeout_cycles;
   logic           full, readout_ack;
`ifdef BANYAN_SEQ_LOOP_EN
   logic           loop_en;
`endif
   logic [7:0]     banyan_mask;
   logic           capture_trig, readout_req, busy, done, timeout_err;
   logic [SAW-1:0] step_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int trig_cnt = 0;
   int done_cnt = 0;

   banyan_capture_sequencer #(.SAW(SAW), .TW(TW), .SW(SW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .mask_we        (mask_we),
      .mask_waddr     (mask_waddr),
      .mask_wdata     (mask_wdata),
      .n_steps        (n_steps),
      .settle_cycles  (settle_cycles),
      .timeout_cycles (timeout_cycles),
      .full           (full),
      .readout_ack    (readout_ack),
`ifdef BANYAN_SEQ_LOOP_EN
      .loop_en        (loop_en),
`endif
      .banyan_mask    (banyan_mask),
      .capture_trig   (capture_trig),
      .readout_req    (readout_req),
      .busy           (busy),
      .done           (done),
      .timeout_err    (timeout_err),
      .step_idx       (step_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (capture_trig === 1'b1) trig_cnt++;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_mask(input logic [SAW-1:0] a, input logic [7:0] d);
      mask_we = 1'b1; mask_waddr = a; mask_wdata = d;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_trig(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (capture_trig === 1'b1) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (readout_req === 1'b1) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   // trigger seen -> full raised after the blank window -> wait for request
   task automatic serve_to_req(input string tag);
      wait_trig({tag, "_trig"});
      ticks(3);
      full = 1'b1;
      wait_req({tag, "_req"});
      full = 1'b0;
   endtask

   task automatic ack_pulse();
      readout_ack = 1'b1;
      tick();
      readout_ack = 1'b0;
   endtask

   // Test-1 step: entered right after the edge that moved the FSM into LOAD.
   // settle=3: mask visible one edge after LOAD, trig 4 edges later,
   // full raised 10 edges after trig, ack 5 edges after req.
   task automatic do_step(input int idx, input logic [7:0] m, input bit last);
      chk($sformatf("t1_step_idx%0d", idx), 32'(step_idx), 32'(idx));
      tick();
      chk($sformatf("t1_mask%0d", idx), 32'(banyan_mask), 32'(m));
      ticks(3);
      chk($sformatf("t1_notrig%0d", idx), 32'(capture_trig), 32'd0);
      tick();
      chk($sformatf("t1_trig%0d", idx), 32'(capture_trig), 32'd1);
      tick();
      chk($sformatf("t1_trig_single%0d", idx), 32'(capture_trig), 32'd0);
      ticks(8);
      chk($sformatf("t1_noreq%0d", idx), 32'(readout_req), 32'd0);
      full = 1'b1;
      tick();
      full = 1'b0;
      chk($sformatf("t1_req%0d", idx), 32'(readout_req), 32'd1);
      ticks(4);
      chk($sformatf("t1_req_hold%0d", idx), 32'(readout_req), 32'd1);
      ack_pulse();
      chk($sformatf("t1_req_drop%0d", idx), 32'(readout_req), 32'd0);
      chk($sformatf("t1_done%0d", idx), 32'(done), 32'(last));
      chk($sformatf("t1_busy%0d", idx), 32'(busy), 32'(!last));
      if (last) begin
         chk("t1_mask_held", 32'(banyan_mask), 32'(m));
         tick();
         chk("t1_done_pulse_end", 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask_we = 1'b0;
      mask_waddr = '0; mask_wdata = '0; n_steps = '0;
      settle_cycles = '0; timeout_cycles = '0; full = 1'b0; readout_ack = 1'b0;
`ifdef BANYAN_SEQ_LOOP_EN
      loop_en = 1'b0;
`endif
      ticks(3);
      chk("rst_mask", 32'(banyan_mask), 32'd0);
      chk("rst_trig", 32'(capture_trig), 32'd0);
      chk("rst_req", 32'(readout_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk("rst_step", 32'(step_idx), 32'd0);
      rst_n = 1'b1;
      tick();

      write_mask(2'd0, 8'h01);
      write_mask(2'd1, 8'h02);
      write_mask(2'd2, 8'h04);
      write_mask(2'd3, 8'h08);

      // Test 1: four-step sequence
      n_steps = 3'd4; settle_cycles = 8'd3; timeout_cycles = '0;
      trig_cnt = 0; done_cnt = 0;
      pulse_start();
      chk("t1_busy_start", 32'(busy), 32'd1);
      do_step(0, 8'h01, 1'b0);
      do_step(1, 8'h02, 1'b0);
      do_step(2, 8'h04, 1'b0);
      do_step(3, 8'h08, 1'b1);
      chk("t1_trig_count", 32'(trig_cnt), 32'd4);
      chk("t1_done_count", 32'(done_cnt), 32'd1);

      // Test 2: fill timeout, full never arrives
      n_steps = 3'd2; timeout_cycles = 20'd50;
      trig_cnt = 0; done_cnt = 0;
      pulse_start();
      wait_trig("t2_trig");
      ticks(51);
      chk("t2_terr_early", 32'(timeout_err), 32'd0);
      chk("t2_busy_early", 32'(busy), 32'd1);
      tick();
      chk("t2_terr", 32'(timeout_err), 32'd1);
      chk("t2_mask", 32'(banyan_mask), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);
      tick();
      chk("t2_terr_sticky", 32'(timeout_err), 32'd1);
      chk("t2_trig_count", 32'(trig_cnt), 32'd1);
      chk("t2_done_count", 32'(done_cnt), 32'd0);

      // Test 4: start while busy ignored; start clears timeout_err
      n_steps = 3'd1; settle_cycles = 8'd0; timeout_cycles = '0;
      trig_cnt = 0; done_cnt = 0;
      pulse_start();
      chk("t4_terr_clr", 32'(timeout_err), 32'd0);
      ticks(2);
      chk("t4_trig", 32'(capture_trig), 32'd1);
      pulse_start();
      ticks(5);
      full = 1'b1;
      tick();
      full = 1'b0;
      chk("t4_req", 32'(readout_req), 32'd1);
      ack_pulse();
      chk("t4_done", 32'(done), 32'd1);
      ticks(10);
      chk("t4_trig_count", 32'(trig_cnt), 32'd1);
      chk("t4_busy_after", 32'(busy), 32'd0);
      n_steps = 3'd0;
      pulse_start();
      chk("t4_nsteps0_busy", 32'(busy), 32'd0);
      tick();
      chk("t4_nsteps0_busy2", 32'(busy), 32'd0);

      // Test 3: abort during READOUT of step 1, late ack ignored
      n_steps = 3'd4; done_cnt = 0;
      pulse_start();
      serve_to_req("t3_s0");
      ack_pulse();
      serve_to_req("t3_s1");
      chk("t3_step1", 32'(step_idx), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_req", 32'(readout_req), 32'd0);
      chk("t3_mask", 32'(banyan_mask), 32'd0);
      chk("t3_step", 32'(step_idx), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      ack_pulse();
      tick();
      chk("t3_late_ack_busy", 32'(busy), 32'd0);
      chk("t3_late_ack_req", 32'(readout_req), 32'd0);
      chk("t3_done_count", 32'(done_cnt), 32'd0);

      // n_steps above the table depth saturates to 4 steps
      n_steps = 3'd7; trig_cnt = 0; done_cnt = 0;
      pulse_start();
      for (int s = 0; s < 4; s++) begin
         serve_to_req($sformatf("sat_s%0d", s));
         ack_pulse();
      end
      chk("sat_done", 32'(done_cnt), 32'd1);
      chk("sat_trig_count", 32'(trig_cnt), 32'd4);

`ifdef BANYAN_SEQ_LOOP_EN
      // Test 6a: looping sequence
      n_steps = 3'd2; loop_en = 1'b1; done_cnt = 0;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         wait_trig($sformatf("loop_trig%0d", k));
         chk($sformatf("loop_mask%0d", k), 32'(banyan_mask), (k % 2 == 0) ? 32'h01 : 32'h02);
         ticks(3);
         full = 1'b1;
         wait_req($sformatf("loop_req%0d", k));
         full = 1'b0;
         ack_pulse();
      end
      chk("loop_no_done", 32'(done_cnt), 32'd0);
      chk("loop_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      loop_en = 1'b0;
      chk("loop_abort_busy", 32'(busy), 32'd0);
`endif

      // Test 5: stale full across trig; mask write after LOAD not visible
      n_steps = 3'd1; done_cnt = 0;
      full = 1'b1;
      pulse_start();
      wait_trig("t5_trig");
      write_mask(2'd0, 8'hAA);
      chk("t5_mask_kept", 32'(banyan_mask), 32'h01);
      chk("t5_noreq1", 32'(readout_req), 32'd0);
      tick();
      chk("t5_noreq2", 32'(readout_req), 32'd0);
      tick();
      chk("t5_noreq3", 32'(readout_req), 32'd0);
      tick();
      chk("t5_req", 32'(readout_req), 32'd1);
      full = 1'b0;
      ack_pulse();
      chk("t5_done", 32'(done), 32'd1);

      // Test 6b: reset mid-FILL clears everything asynchronously
      pulse_start();
      wait_trig("t6_trig");
      ticks(2);
      chk("t6_mask_pre", 32'(banyan_mask), 32'hAA);
      chk("t6_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_mask", 32'(banyan_mask), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_trig0", 32'(capture_trig), 32'd0);
      chk("t6_req", 32'(readout_req), 32'd0);
      chk("t6_step", 32'(step_idx), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      tick();
      chk("t6_busy_restart", 32'(busy), 32'd1);
      chk("t6_table_cleared", 32'(banyan_mask), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6_abort_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
